// File: rtl/mdu_iter_if.sv
// Issue/result bundle between pipeline control and the iterative multiply/divide unit.
// The issuer drives start/op/in1/in2; the unit returns busy/done, HI/LO and the divide-by-zero flag.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, in1, in2,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, in1, in2,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle, results in HI/LO.
// Optional MDU_EARLY_OUT_EN: multiplies stop as soon as the remaining multiplier bits are zero.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    mdu_iter_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         r_state;
    logic               r_is_div;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_div0;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Issue-side decode: magnitude of a WIDTH-bit two's complement value always fits WIDTH unsigned bits
    logic             w_is_div;
    logic             w_signed;
    logic             w_s1;
    logic             w_s2;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic             w_div0_in;
    logic             w_skip;

    assign w_is_div  = bus.op[1];
    assign w_signed  = ~bus.op[0];
    assign w_s1      = w_signed & bus.in1[WIDTH-1];
    assign w_s2      = w_signed & bus.in2[WIDTH-1];
    assign w_mag1    = w_s1 ? (-bus.in1) : bus.in1;
    assign w_mag2    = w_s2 ? (-bus.in2) : bus.in2;
    assign w_div0_in = w_is_div & (bus.in2 == '0);

    // Multiply step: conditional add into the upper half, then shift the pair right with carry-in
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    assign w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:1]};

    // Divide step: shifted remainder is WIDTH+1 bits wide, so compare before subtracting
    logic [WIDTH:0]     w_rem_sh;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_div_step;

    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_ge   = (w_rem_sh >= {1'b0, r_opnd});
    assign w_div_diff = WIDTH'(w_rem_sh - {1'b0, r_opnd});
    assign w_div_step = w_div_ge ? {w_div_diff, r_acc[WIDTH-2:0], 1'b1}
                                 : {r_acc[2*WIDTH-2:0], 1'b0};

    logic [2*WIDTH-1:0] w_step;
    logic               w_last;
    logic               w_exit;
    logic [2*WIDTH-1:0] w_calc_acc;

    assign w_step = r_is_div ? w_div_step : w_mul_step;
    assign w_last = (r_cnt == LAST_ITER);

`ifdef MDU_EARLY_OUT_EN
    logic [WIDTH-1:0] r_mrem;
    logic             w_mul_exit;
    logic [CW-1:0]    w_shamt;

    // Skipped shifts leave the product sitting high in the accumulator; realign it on exit
    assign w_mul_exit = ~r_is_div & ((r_mrem >> 1) == '0);
    assign w_exit     = w_last | w_mul_exit;
    assign w_shamt    = CW'(WIDTH) - r_cnt - CW'(1);
    assign w_calc_acc = w_mul_exit ? (w_step >> w_shamt) : w_step;
    assign w_skip     = w_div0_in | (~w_is_div & (bus.in2 == '0));
`else
    assign w_exit     = w_last;
    assign w_calc_acc = w_step;
    assign w_skip     = w_div0_in;
`endif

    // Sign fix-up applied in FIX
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_prod = r_neg_lo ? (-r_acc) : r_acc;
    assign w_quot = r_neg_lo ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_hi ? (-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_div0   <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef MDU_EARLY_OUT_EN
            r_mrem   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= bus.start;
                    if (bus.start) begin
                        r_is_div <= w_is_div;
                        r_neg_lo <= w_s1 ^ w_s2;
                        r_neg_hi <= w_is_div & w_s1;
                        r_div0   <= w_div0_in;
                        r_dbz    <= 1'b0;
                        r_cnt    <= '0;
                        r_opnd   <= w_is_div ? w_mag2 : w_mag1;
                        // Divide-by-zero keeps the raw dividend so HI can return it untouched
                        r_acc    <= {{WIDTH{1'b0}},
                                     w_div0_in ? bus.in1 : (w_is_div ? w_mag1 : w_mag2)};
`ifdef MDU_EARLY_OUT_EN
                        r_mrem   <= w_mag2;
`endif
                        r_state  <= w_skip ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_calc_acc;
                    r_cnt <= r_cnt + CW'(1);
`ifdef MDU_EARLY_OUT_EN
                    r_mrem <= r_mrem >> 1;
`endif
                    if (w_exit) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_div0) begin
                        r_hi  <= r_acc[WIDTH-1:0];
                        r_lo  <= '1;
                        r_dbz <= 1'b1;
                    end else if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases, busy/reset corner cases and random ops
// checked against a plain-arithmetic reference model.
module tb_mdu_iter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mdu_iter_if #(.WIDTH(32)) bus ();

    mdu_iter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: returns {div_by_zero, hi, lo}
    function automatic logic [64:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        logic [64:0] r;
        sa = a;
        sb = b;
        case (op)
            2'd0: begin
                sp = longint'(sa) * longint'(sb);
                r  = {1'b0, 64'(sp)};
            end
            2'd1: begin
                up = {32'd0, a} * {32'd0, b};
                r  = {1'b0, up};
            end
            2'd2: begin
                if (b == 32'd0)                                 r = {1'b1, a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {1'b0, 32'd0, 32'h8000_0000};
                else                                            r = {1'b0, 32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) r = {1'b1, a, 32'hFFFF_FFFF};
                else            r = {1'b0, a % b, a / b};
            end
        endcase
        return r;
    endfunction

    // Edges from acceptance until done is visible
    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
        int          l;
        logic [31:0] m;
        l = 33;
        if (op[1] && b == 32'd0) l = 1;
`ifdef MDU_EARLY_OUT_EN
        if (!op[1]) begin
            m = (op == 2'd0 && b[31]) ? -b : b;
            if (m == 32'd0) l = 1;
            else begin
                for (int i = 0; i < 32; i++) if (m[i]) l = i + 2;
            end
        end
`else
        m = b;
        if (m == 32'hDEAD_0000) l = 33;
`endif
        return l;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit b2b,
                          output int lat, output int bcnt, output logic [31:0] hi, output logic [31:0] lo,
                          output logic dz, output logic dz_acc, output bit seen);
        if (!b2b) begin
            @(posedge clk); #1;
        end
        bus.start = 1'b1;
        bus.op    = op;
        bus.in1   = a;
        bus.in2   = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.in1   = $urandom;
        bus.in2   = $urandom;
        dz_acc = bus.div_by_zero;
        lat = 0; bcnt = 0; seen = 0;
        hi = 'x; lo = 'x; dz = 1'bx;
        repeat (200) begin
            if (bus.busy) bcnt++;
            if (bus.done) begin
                seen = 1;
                hi = bus.hi; lo = bus.lo; dz = bus.div_by_zero;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        $display("op=%0d in1=%h in2=%h -> hi=%h lo=%h dz=%b lat=%0d busy=%0d", op, a, b, hi, lo, dz, lat, bcnt);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'd0; bus.in1 = '0; bus.in2 = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo} !== 67'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h want all zero",
                     bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [6] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd1};
        logic [31:0] as  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'd2};
        logic [31:0] bs  [6] = '{32'd7, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd3};
        logic [31:0] ehi [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd100, 32'd0};
        logic [31:0] elo [6] = '{32'hFFFF_FFEB, 32'h0000_0001, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd6};
        logic        edz [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int lat, bcnt; logic [31:0] hi, lo; logic dz, dz_acc; bit seen;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], 1'b0, lat, bcnt, hi, lo, dz, dz_acc, seen);
            total++;
            if (!seen || hi !== ehi[i] || lo !== elo[i] || dz !== edz[i]) begin
                bad++;
                $display("FAIL directed_%0d: got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b", i, hi, lo, dz, ehi[i], elo[i], edz[i]);
            end
            total++;
            if (lat !== exp_lat(ops[i], bs[i]) || bcnt !== lat + 1) begin
                bad++;
                $display("FAIL directed_lat_%0d: got lat=%0d busy=%0d want lat=%0d busy=%0d", i, lat, bcnt,
                         exp_lat(ops[i], bs[i]), exp_lat(ops[i], bs[i]) + 1);
            end
            if (i == 5) begin
                total++;
                if (dz_acc !== 1'b0) begin
                    bad++;
                    $display("FAIL dz_clear: got %b want 0 after next accepted start", dz_acc);
                end
            end
        end
        @(posedge clk); #1;
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: got done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_idle_hold();
        repeat (5) begin
            bus.in1 = $urandom; bus.in2 = $urandom; bus.op = 2'($urandom);
            @(posedge clk); #1;
        end
        total++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd6 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: got hi=%h lo=%h busy=%b want hi=0 lo=6 busy=0", bus.hi, bus.lo, bus.busy);
        end
    endtask

    task automatic test_busy_ignore();
        int dones, pulse_at; logic [31:0] hi, lo;
        pulse_at = (exp_lat(2'd1, 32'd6) > 11) ? 10 : 1;
        dones = 0; hi = 'x; lo = 'x;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 2'd1; bus.in1 = 32'd5; bus.in2 = 32'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (bus.done) begin
                dones++; hi = bus.hi; lo = bus.lo;
            end
            if (c == pulse_at) begin
                bus.start = 1'b1; bus.op = 2'd3; bus.in1 = 32'd9; bus.in2 = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        $display("busy_ignore: dones=%0d hi=%h lo=%h", dones, hi, lo);
        total++;
        if (dones !== 1 || lo !== 32'd30 || hi !== 32'd0) begin
            bad++;
            $display("FAIL busy_ignore: got dones=%0d hi=%h lo=%h want dones=1 hi=0 lo=1e", dones, hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        int dones, lat, bcnt; logic [31:0] hi, lo; logic dz, dz_acc; bit seen;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 2'd2; bus.in1 = 32'd50; bus.in2 = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0) begin
            bad++;
            $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want all zero", bus.busy, bus.done, bus.hi, bus.lo);
        end
        rst_n = 1'b1;
        dones = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL reset_abandon: got %0d done pulses want 0", dones);
        end
        run_op(2'd3, 32'd50, 32'd7, 1'b0, lat, bcnt, hi, lo, dz, dz_acc, seen);
        total++;
        if (!seen || lo !== 32'd7 || hi !== 32'd1) begin
            bad++;
            $display("FAIL after_reset: got hi=%h lo=%h want hi=1 lo=7", hi, lo);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 300));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random(input int n, input bit b2b_pairs);
        int lat, bcnt; logic [31:0] hi, lo, a, b; logic dz, dz_acc; bit seen;
        logic [1:0] op; logic [64:0] e;
        for (int i = 0; i < n; i++) begin
            op = 2'($urandom);
            a = pick_operand();
            b = pick_operand();
            e = ref_op(op, a, b);
            run_op(op, a, b, b2b_pairs && (i % 2 == 1), lat, bcnt, hi, lo, dz, dz_acc, seen);
            total++;
            if (!seen || {dz, hi, lo} !== e) begin
                bad++;
                $display("FAIL %s_%0d: op=%0d in1=%h in2=%h got dz=%b hi=%h lo=%h want dz=%b hi=%h lo=%h",
                         b2b_pairs ? "b2b" : "random", i, op, a, b, dz, hi, lo, e[64], e[63:32], e[31:0]);
            end
            total++;
            if (lat !== exp_lat(op, b) || bcnt !== lat + 1) begin
                bad++;
                $display("FAIL %s_lat_%0d: got lat=%0d busy=%0d want lat=%0d", b2b_pairs ? "b2b" : "random", i,
                         lat, bcnt, exp_lat(op, b));
            end
        end
    endtask

    task automatic test_back_to_back();
        test_random(8, 1'b1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        test_reset();
        test_directed();
        test_idle_hold();
        test_busy_ignore();
        test_reset_mid();
        test_random(40, 1'b0);
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
